// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search datapath.
package rc4_pkg;

  // Default widths for the candidate key and the 256x8 S-memory.
  localparam int KEY_W_DEF  = 22;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Encrypted message geometry, shared with the PRGA client.
  localparam int MSG_LEN    = 32;
  localparam int MSG_ADDR_W = 5;

  // Search sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_INIT  = 3'd2,
    ST_KSA   = 3'd3,
    ST_PRGA  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_FOUND = 3'd6,
    ST_FAIL  = 3'd7
  } rc4_state_e;

  // True while a candidate key is being processed.
  function automatic logic state_is_busy(input rc4_state_e s);
    return (s == ST_CLR) || (s == ST_INIT) || (s == ST_KSA) ||
           (s == ST_PRGA) || (s == ST_NEXT);
  endfunction

endpackage

// File: rtl/s_mem_mux.sv
// S-memory write-port arbiter: grants the port to the client owning the
// current phase and forces address, data and write enable to zero otherwise.
module s_mem_mux
  import rc4_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  rc4_state_e        state,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_data,
  input  logic              ksa_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren
);

  logic sel_init;
  logic sel_ksa;

  assign sel_init = (state == ST_INIT);
  assign sel_ksa  = (state == ST_KSA);

  // AND-OR select per bit: at most one select is high, none outside INIT/KSA.
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_addr
      assign mem_addr[gi] = (sel_init & init_addr[gi]) | (sel_ksa & ksa_addr[gi]);
    end
    for (gi = 0; gi < DATA_W; gi++) begin : g_data
      assign mem_data[gi] = (sel_init & init_data[gi]) | (sel_ksa & ksa_data[gi]);
    end
  endgenerate

  // A non-owner write enable can never reach the memory.
  assign mem_wren = (sel_init & init_wren) | (sel_ksa & ksa_wren);

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// RC4 key-search sequencer: for each candidate key runs clear -> S init ->
// KSA -> PRGA, stepping the key until plaintext is found or keys run out.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int              KEY_W     = KEY_W_DEF,
  parameter logic [KEY_W-1:0] KEY_START = '0,
  parameter logic [KEY_W-1:0] KEY_MAX   = '1,
  parameter int              ADDR_W    = ADDR_W_DEF,
  parameter int              DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  output logic              client_clr,
  output logic              init_start,
  input  logic              init_done,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic              init_wren,
  output logic              ksa_start,
  input  logic              ksa_done,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_data,
  input  logic              ksa_wren,
  output logic              prga_start,
  input  logic              prga_done,
  input  logic              prga_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic [KEY_W-1:0]  key,
  output logic              busy,
  output logic              found,
  output logic              exhausted
);

  rc4_state_e       state_reg, state_next;
  logic [KEY_W-1:0] key_reg, key_next;
  logic             found_reg, found_next;
  logic             exhausted_reg, exhausted_next;

  // State, key counter and sticky status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      key_reg       <= KEY_START;
      found_reg     <= 1'b0;
      exhausted_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      key_reg       <= key_next;
      found_reg     <= found_next;
      exhausted_reg <= exhausted_next;
    end
  end

  // Next-state and key/status update; every phase always passes through CLR
  // first so a done left high by the previous key cannot advance INIT.
  always_comb begin
    state_next     = state_reg;
    key_next       = key_reg;
    found_next     = found_reg;
    exhausted_next = exhausted_reg;
    case (state_reg)
      ST_IDLE, ST_FOUND, ST_FAIL: begin
        if (go) begin
          key_next       = KEY_START;
          found_next     = 1'b0;
          exhausted_next = 1'b0;
          state_next     = ST_CLR;
        end
      end
      ST_CLR:  state_next = ST_INIT;
      ST_INIT: if (init_done) state_next = ST_KSA;
      ST_KSA:  if (ksa_done)  state_next = ST_PRGA;
      ST_PRGA: begin
        if (prga_done) begin
          if (prga_valid) begin
            found_next = 1'b1;
            state_next = ST_FOUND;
          end else begin
            state_next = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (key_reg == KEY_MAX) begin
          exhausted_next = 1'b1;
          state_next     = ST_FAIL;
        end else begin
          key_next   = key_reg + 1'b1;
          state_next = ST_CLR;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Moore phase strobes and status decoded from the registered state.
  assign client_clr = (state_reg == ST_CLR);
  assign init_start = (state_reg == ST_INIT);
  assign ksa_start  = (state_reg == ST_KSA);
  assign prga_start = (state_reg == ST_PRGA);
  assign busy       = state_is_busy(state_reg);
  assign found      = found_reg;
  assign exhausted  = exhausted_reg;
  assign key        = key_reg;

  s_mem_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_s_mem_mux (
    .state     (state_reg),
    .init_addr (init_addr),
    .init_data (init_data),
    .init_wren (init_wren),
    .ksa_addr  (ksa_addr),
    .ksa_data  (ksa_data),
    .ksa_wren  (ksa_wren),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_wren  (mem_wren)
  );

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl with behavioural init/KSA/PRGA client stubs
// and a scoreboard of candidate keys expected at each client_clr pulse.
module tb_rc4_key_search_ctrl;
  import rc4_pkg::*;

  localparam int KEY_W    = 22;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int KSA_LEN  = 6;
  localparam int PRGA_LEN = 4;
  localparam int BOUND    = 20000;

  logic              clk;
  logic              reset_n;
  logic              go;
  logic              client_clr;
  logic              init_start;
  logic              init_done;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic              init_wren;
  logic              ksa_start;
  logic              ksa_done;
  logic [ADDR_W-1:0] ksa_addr;
  logic [DATA_W-1:0] ksa_data;
  logic              ksa_wren;
  logic              prga_start;
  logic              prga_done;
  logic              prga_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [KEY_W-1:0]  key;
  logic              busy;
  logic              found;
  logic              exhausted;

  int checks   = 0;
  int failures = 0;

  logic [KEY_W-1:0] exp_key_q[$];
  logic             valid_en;
  logic [KEY_W-1:0] valid_key;

  rc4_key_search_ctrl #(
    .KEY_W     (KEY_W),
    .KEY_START (22'd0),
    .KEY_MAX   (22'd3),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .go         (go),
    .client_clr (client_clr),
    .init_start (init_start),
    .init_done  (init_done),
    .init_addr  (init_addr),
    .init_data  (init_data),
    .init_wren  (init_wren),
    .ksa_start  (ksa_start),
    .ksa_done   (ksa_done),
    .ksa_addr   (ksa_addr),
    .ksa_data   (ksa_data),
    .ksa_wren   (ksa_wren),
    .prga_start (prga_start),
    .prga_done  (prga_done),
    .prga_valid (prga_valid),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .key        (key),
    .busy       (busy),
    .found      (found),
    .exhausted  (exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- client stubs ----------------
  logic [8:0] init_cnt;
  logic [7:0] ksa_cnt;
  logic [7:0] prga_cnt;

  // Init stub: 256 writes of data ~addr, then done held until cleared.
  always @(posedge clk) begin
    if (!reset_n || client_clr) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (init_start && !init_done) begin
      if (init_cnt == 9'd256) init_done <= 1'b1;
      else                    init_cnt  <= init_cnt + 9'd1;
    end
  end
  assign init_addr = init_cnt[7:0];
  assign init_data = ~init_cnt[7:0];
  assign init_wren = init_start && !init_done && (init_cnt < 9'd256);

  // KSA stub: fixed-length phase; its wren is tied high to probe masking.
  always @(posedge clk) begin
    if (!reset_n || client_clr) begin
      ksa_cnt  <= '0;
      ksa_done <= 1'b0;
    end else if (ksa_start && !ksa_done) begin
      if (ksa_cnt == KSA_LEN[7:0]) ksa_done <= 1'b1;
      else                         ksa_cnt  <= ksa_cnt + 8'd1;
    end
  end
  assign ksa_addr = ksa_cnt + 8'h40;
  assign ksa_data = ksa_cnt ^ 8'hA5;
  assign ksa_wren = 1'b1;

  // PRGA stub: plaintext judged readable only for the chosen key.
  always @(posedge clk) begin
    if (!reset_n || client_clr) begin
      prga_cnt  <= '0;
      prga_done <= 1'b0;
    end else if (prga_start && !prga_done) begin
      if (prga_cnt == PRGA_LEN[7:0]) prga_done <= 1'b1;
      else                           prga_cnt  <= prga_cnt + 8'd1;
    end
  end
  assign prga_valid = prga_done && valid_en && (key == valid_key);

  // ---------------- monitor ----------------
  // Memory port must mirror the phase owner; scoreboard pops at each clear.
  always @(negedge clk) begin
    logic [KEY_W-1:0] e;
    if (init_start) begin
      check_eq("mux_init_addr", mem_addr, init_addr);
      check_eq("mux_init_data", mem_data, init_data);
      check_eq("mux_init_wren", mem_wren, init_wren);
    end else if (ksa_start) begin
      check_eq("mux_ksa_addr", mem_addr, ksa_addr);
      check_eq("mux_ksa_data", mem_data, ksa_data);
      check_eq("mux_ksa_wren", mem_wren, ksa_wren);
    end else begin
      check_eq("mux_idle_wren", mem_wren, 1'b0);
      check_eq("mux_idle_addr", mem_addr, '0);
    end
    if (client_clr) begin
      if (exp_key_q.size() == 0) begin
        check_eq("clr_extra", exp_key_q.size(), 1);
      end else begin
        e = exp_key_q.pop_front();
        check_eq("clr_key", key, e);
        $display("key_try key=%0d expected=%0d", key, e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_search(input int first, input int last);
    for (int k = first; k <= last; k++) exp_key_q.push_back(k[KEY_W-1:0]);
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1;
    check_eq("go_found_clr", found, 1'b0);
    check_eq("go_exh_clr", exhausted, 1'b0);
    check_eq("go_key_start", key, first);
    check_eq("go_busy", busy, 1'b1);
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_eq({tag, "_timeout"}, busy, 1'b0);
  endtask

  task automatic wait_ksa_key(input logic [KEY_W-1:0] k, input string tag);
    int n = 0;
    while (!(ksa_start && key == k) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!(ksa_start && key == k)) check_eq({tag, "_timeout"}, ksa_start, 1'b1);
  endtask

  task automatic check_result(input string tag, input logic f, input logic x, input logic [KEY_W-1:0] k);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_found"}, found, f);
    check_eq({tag, "_exhausted"}, exhausted, x);
    check_eq({tag, "_key"}, key, k);
    check_eq({tag, "_sb_empty"}, exp_key_q.size(), 0);
    $display("search %s: key=%0d found=%0d exhausted=%0d", tag, key, found, exhausted);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_n   = 1'b0;
    go        = 1'b0;
    valid_en  = 1'b0;
    valid_key = '0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_found", found, 1'b0);
    check_eq("rst_exhausted", exhausted, 1'b0);
    check_eq("rst_key", key, 22'd0);
    check_eq("rst_wren", mem_wren, 1'b0);
    check_eq("rst_clr", client_clr, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // First key readable: exactly one clear pulse, found with key 0.
    valid_en  = 1'b1;
    valid_key = 22'd0;
    start_search(0, 0);
    wait_idle("first");
    check_result("first", 1'b1, 1'b0, 22'd0);

    // Go from FOUND, no key readable; a go pulse mid-search is ignored.
    valid_en = 1'b0;
    start_search(0, 3);
    wait_ksa_key(22'd1, "busy_go");
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check_eq("busy_go_key", key, 22'd1);
    wait_idle("exhaust");
    check_result("exhaust", 1'b0, 1'b1, 22'd3);

    // Reset in the middle of KSA for key 2 while ksa_wren is high.
    start_search(0, 2);
    wait_ksa_key(22'd2, "midksa");
    check_eq("midksa_wren_pre", mem_wren, 1'b1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midksa_busy", busy, 1'b0);
    check_eq("midksa_ksa_start", ksa_start, 1'b0);
    check_eq("midksa_wren", mem_wren, 1'b0);
    check_eq("midksa_key", key, 22'd0);
    check_eq("midksa_exhausted", exhausted, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    check_eq("midksa_sb_empty", exp_key_q.size(), 0);

    // From IDLE, key 2 readable.
    valid_en  = 1'b1;
    valid_key = 22'd2;
    start_search(0, 2);
    wait_idle("third");
    check_result("third", 1'b1, 1'b0, 22'd2);

    // Status held in FOUND while go stays low.
    repeat (5) @(negedge clk);
    check_eq("hold_found", found, 1'b1);
    check_eq("hold_clr", client_clr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
